cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Pipelined, handshaked wide adder built from cla16 slices, one slice per pipeline stage.
//  Sits downstream of the operand/ALU issue logic and wraps cla16: each stage adds one 16-bit slice.
//  Each stage forms the slice carry-out from the slice's gx/px and registers it for the next stage.
//  Throughput 1 op/cycle; latency N_SLICE cycles; full valid/ready backpressure.
// PARAMETERS
//  N_SLICE  2  number of 16-bit cla16 slices and pipeline stages; W = 16*N_SLICE; legal 1..4
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  operand beat valid
//  in_ready   out  1  block accepts beat this cycle
//  in_a       in   W  operand A
//  in_b       in   W  operand B
//  in_cin     in   1  carry-in (add only)
//  in_sub     in   1  1: A-B (B inverted, carry-in forced 1, in_cin ignored)
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  out_sum    out  W  result, bits [W-1:0]
//  out_cout   out  1  carry out of bit W-1 (for sub: 1 = no borrow)
//  out_ovf    out  1  signed overflow (CLA_PIPE_FLAGS_EN only)
//  out_zero   out  1  out_sum == 0 (CLA_PIPE_FLAGS_EN only)
// BEHAVIOUR
//  - Reset: every stage valid bit, out_valid, out_sum, out_cout, out_ovf, out_zero = 0; in_ready = 1 after reset.
//  - Reset asserted mid-operation drops all in-flight beats; nothing is emitted after release.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Stage k (0..N_SLICE-1) holds valid_k, the running carry c_k, the sum bits below slice k, and operand bits at and above slice k.
//  - Stage 0 adds slice 0 combinationally at input, with carry = in_sub ? 1 : in_cin.
//    Stage k adds slice k from its registered carry.
//  - Slice carry-out: c_next = gx | (px & c_k), where px/gx are the cla16 outputs for that slice.
//  - Slice bit mapping: W bits [16j+15:16j] map to cla16 A/B/S[16:1].
//  - Last stage register drives out_*; out_sum/out_cout are registered, no combinational in->out path.
//  - Advance rule: stage k loads when !valid_k | stage k advances onward. Last stage advances onward when out_ready.
//  - in_ready = stage 0 load condition. A full pipe with out_ready=1 accepts and emits every cycle.
//  - Stall (out_ready=0, pipe full): all stage registers hold; out_* stable; in_ready=0.
//  - Bubbles are collapsed: a beat behind an empty stage advances even while out_ready=0.
//  - Wrap-around: the sum is modulo 2^W; the carry is reported only on out_cout.
//  - Results leave in input order; no reordering and no drops while rst_n=1.
//  - N_SLICE=1: a single registered stage, latency 1.
// CONFIGURATION
//  CLA_PIPE_FLAGS_EN defined:
//   - out_ovf = carry into MSB ^ out_cout, using the effective (inverted for sub) B.
//   - out_zero = ~|sum.
//   - Both are computed in the last stage and registered alongside out_sum. Reset value 0.
//  CLA_PIPE_FLAGS_EN undefined: out_ovf and out_zero ports are absent; no flag logic.
// STRUCTURE
//  - Package cla_pipe_pkg:
//    - SLICE_W=16 constant
//    - slice_carry() function (gx|px&c)
//    - typedef stage_t {valid, carry, sum bits, operand bits}
//  - Sub-module: cla_pipe_stage, one per slice via generate.
//    - Instantiates one cla16 and the stage register.
//    - Implements the stage-local load/advance handshake.
//  - Top: generate chain of stages, input carry/sub muxing, output drive, optional flags.
// TESTING
//  - Reset: rst_n=0 with in_valid=1 -> out_valid=0, out_sum=0, in_ready=1 after release; no output beat appears.
//  - N_SLICE=2 add 0x0000FFFF+0x00000001, cin=0 -> after 2 cycles sum=0x00010000, cout=0 (cross-slice carry).
//  - 0xFFFFFFFF+0x00000000, cin=1 -> sum=0x00000000, cout=1; with flags: zero=1, ovf=0.
//  - Sub 0x80000000-0x00000001 -> sum=0x7FFFFFFF, cout=1; with flags: ovf=1.
//  - Backpressure: 8 back-to-back random beats, out_ready toggling 1/0 -> results in order and match a+b+cin mod 2^32; in_ready=0 only when full and stalled.
//  - Mid-stream reset: 2 beats in flight, pulse rst_n low -> both beats dropped; next beat returns correct after 2 cycles.

Source files
------------

// File: rtl/cla_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Optional flag outputs are enabled with the CLA_PIPE_FLAGS_EN macro.
package cla_pipe_pkg;

  localparam int SLICE_W   = 16;
  localparam int MAX_SLICE = 4;
  localparam int MAX_W     = SLICE_W * MAX_SLICE;

  // One pipeline beat: valid flag, running carry, sum bits produced so far
  // and the (effective) operands still to be added. Fields are sized for
  // the widest legal configuration; narrower builds leave the top bits zero.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

  // Carry out of a slice from its group generate/propagate and carry-in.
  function automatic logic slice_carry(input logic gx, input logic px, input logic c);
    return gx | (px & c);
  endfunction

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second lookahead level. Exports group generate/propagate so callers can
// chain slices without waiting on the internal carry path.
module cla16 (
  input  logic [16:1] a,
  input  logic [16:1] b,
  input  logic        cin,
  output logic [16:1] s,
  output logic        px,
  output logic        gx
);

  logic [16:1] g_s;
  logic [16:1] p_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [3:0]  cg_s;
  logic [15:0] c_s;

  // Bit and group generate/propagate, group carries, then the per-bit carries and sum.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = 4'b0000;
    gp_s = 4'b0000;
    cg_s = 4'b0000;
    c_s  = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      gp_s[j] = &p_s[4*j+1 +: 4];
      gg_s[j] = g_s[4*j+4]
              | (p_s[4*j+4] & g_s[4*j+3])
              | (p_s[4*j+4] & p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+4] & p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1]);
    end
    cg_s[0] = cin;
    cg_s[1] = gg_s[0] | (gp_s[0] & cin);
    cg_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
    cg_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
            | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
    // c_s[i] is the carry out of bit i (carry into bit i+1); c_s[0] is the carry-in.
    c_s[0] = cin;
    for (int i = 1; i < 16; i++) begin
      if ((i % 4) == 0) begin
        c_s[i] = cg_s[i/4];
      end else begin
        c_s[i] = g_s[i] | (p_s[i] & c_s[i-1]);
      end
    end
    s  = p_s ^ c_s;
    px = &gp_s;
    gx = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
       | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0]);
  end

endmodule

// File: rtl/cla_pipe_stage.sv
// One pipeline stage: adds 16-bit slice IDX of the incoming beat with a
// cla16, forms the slice carry-out from gx/px and registers the result.
// The register takes a new beat (or a bubble) whenever load is high.
module cla_pipe_stage
  import cla_pipe_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t up,
  input  logic   load,
  output stage_t nxt,
  output stage_t q
);

  localparam int LO = IDX * SLICE_W;

  logic [SLICE_W:1] s_s;
  logic             px_s;
  logic             gx_s;

  cla16 u_cla16 (
    .a   (up.a[LO +: SLICE_W]),
    .b   (up.b[LO +: SLICE_W]),
    .cin (up.carry),
    .s   (s_s),
    .px  (px_s),
    .gx  (gx_s)
  );

  // Next beat: the upstream beat with this slice's sum and carry filled in.
  always_comb begin
    nxt                    = up;
    nxt.sum[LO +: SLICE_W] = s_s;
    nxt.carry              = slice_carry(gx_s, px_s, up.carry);
  end

  // Stage register: take the next beat when allowed, otherwise hold (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= nxt;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined, handshaked wide adder: N_SLICE cla16 slices, one per stage,
// latency N_SLICE, one op per cycle, full valid/ready backpressure.
// Define CLA_PIPE_FLAGS_EN to add registered signed-overflow and zero flags.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int N_SLICE = 2,
  localparam int W      = SLICE_W * N_SLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic         out_ovf,
  output logic         out_zero
`endif
);

  stage_t             head_s;
  stage_t             up_s  [N_SLICE];
  stage_t             nxt_s [N_SLICE];
  stage_t             q_s   [N_SLICE];
  logic [N_SLICE-1:0] vld_s;
  logic [N_SLICE-1:0] load_s;

  // Input beat: subtraction inverts B and forces the carry-in to one.
  always_comb begin
    head_s          = '0;
    head_s.valid    = in_valid;
    head_s.a[W-1:0] = in_a;
    if (in_sub) begin
      head_s.b[W-1:0] = ~in_b;
      head_s.carry    = 1'b1;
    end else begin
      head_s.b[W-1:0] = in_b;
      head_s.carry    = in_cin;
    end
  end

  // Load chain from the output backwards: a stage loads when empty or when
  // its beat moves on, so bubbles collapse even while the consumer stalls.
  always_comb begin
    load_s            = '0;
    load_s[N_SLICE-1] = ~vld_s[N_SLICE-1] | out_ready;
    for (int k = N_SLICE - 2; k >= 0; k--) begin
      load_s[k] = ~vld_s[k] | load_s[k+1];
    end
  end

  for (genvar k = 0; k < N_SLICE; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign up_s[k] = head_s;
    end else begin : g_rest
      assign up_s[k] = q_s[k-1];
    end
    assign vld_s[k] = q_s[k].valid;

    cla_pipe_stage #(
      .IDX (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .up    (up_s[k]),
      .load  (load_s[k]),
      .nxt   (nxt_s[k]),
      .q     (q_s[k])
    );
  end

  assign in_ready  = load_s[0];
  assign out_valid = q_s[N_SLICE-1].valid;
  assign out_sum   = q_s[N_SLICE-1].sum[W-1:0];
  assign out_cout  = q_s[N_SLICE-1].carry;

`ifdef CLA_PIPE_FLAGS_EN
  logic ovf_r;
  logic zero_r;
  logic msb_cin_s;

  // Carry into the MSB recovered from the MSB sum bit and the effective operands.
  always_comb begin
    msb_cin_s = nxt_s[N_SLICE-1].sum[W-1] ^ nxt_s[N_SLICE-1].a[W-1]
              ^ nxt_s[N_SLICE-1].b[W-1];
  end

  // Flags registered alongside the last stage so they track out_sum exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (load_s[N_SLICE-1]) begin
      ovf_r  <= msb_cin_s ^ nxt_s[N_SLICE-1].carry;
      zero_r <= ~|nxt_s[N_SLICE-1].sum[W-1:0];
    end else begin
      ovf_r  <= ovf_r;
      zero_r <= zero_r;
    end
  end

  assign out_ovf  = ovf_r;
  assign out_zero = zero_r;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder with N_SLICE=2 (32 bits).
// Flag checks are included when CLA_PIPE_FLAGS_EN is defined.
module tb_cla_pipe_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CLA_PIPE_FLAGS_EN
  logic         out_ovf;
  logic         out_zero;
`endif

  int errors = 0;
  int checks = 0;

  cla_pipe_adder #(.N_SLICE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CLA_PIPE_FLAGS_EN
    ,
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat to an empty pipe with out_ready=1 and check the
  // result appears exactly two cycles after acceptance.
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(out_sum), 64'(es));
    check({tag, "_cout"}, 64'(out_cout), 64'(ec));
`ifdef CLA_PIPE_FLAGS_EN
    check({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
    check({tag, "_zero"}, 64'(out_zero), 64'(ez));
`else
    if (eo === 1'bx || ez === 1'bx) $display("note: unknown flag expectation in %s", tag);
`endif
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic [32:0] vexp [8];

  initial begin
    int sent;
    int recv;
    int cyc;
    bit in_acc;
    bit out_acc;

    // Reset with in_valid held high: nothing may come out.
    rst_n = 1'b0; in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    in_cin = 1'b1; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
`ifdef CLA_PIPE_FLAGS_EN
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_beat", 64'(out_valid), 64'd0);
    end

    // Directed vectors (expected values worked by hand).
    run_vec("cross_slice", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_vec("wrap_cin",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_vec("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_vec("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_vec("sub_zero",    32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_vec("sub_borrow",  32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back beats, out_ready toggling each cycle.
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1));
      vexp[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {32'd0, vc[i]};
    end
    sent = 0; recv = 0; cyc = 0;
    in_sub = 1'b0;
    while (recv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = ((cyc % 2) == 0);
      if (sent < 8) begin
        in_valid = 1'b1; in_a = va[sent]; in_b = vb[sent]; in_cin = vc[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(!((sent - recv) == 2 && !out_ready)));
      in_acc  = in_valid && in_ready;
      out_acc = out_valid && out_ready;
      if (out_acc) begin
        check("bp_sum", 64'(out_sum), 64'(vexp[recv][31:0]));
        check("bp_cout", 64'(out_cout), 64'(vexp[recv][32]));
      end
      @(posedge clk);
      if (in_acc) sent++;
      if (out_acc) recv++;
      cyc++;
    end
    check("bp_all_received", 64'(recv), 64'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Mid-stream reset: two beats stalled in the pipe, then dropped.
    out_ready = 1'b0;
    in_a = 32'h0000_0001; in_b = 32'h0000_0002; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 32'h0000_0010; in_b = 32'h0000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_sum", 64'(out_sum), 64'h3);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("stall_sum_hold", 64'(out_sum), 64'h3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_dropped", 64'(out_valid), 64'd0);
    end
    run_vec("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
